// File: rtl/gpio_pkg.sv
// Shared register offsets and width limit for the multi-bit Avalon GPIO block.
package gpio_pkg;
    localparam int GPIO_MAX_W = 32;

    localparam logic [3:0] OFF_DATA  = 4'd0;
    localparam logic [3:0] OFF_DIR   = 4'd1;
    localparam logic [3:0] OFF_MASK  = 4'd2;
    localparam logic [3:0] OFF_EDGE  = 4'd3;
    localparam logic [3:0] OFF_SET   = 4'd4;
    localparam logic [3:0] OFF_CLR   = 4'd5;
    localparam logic [3:0] OFF_RISE  = 4'd6;
    localparam logic [3:0] OFF_FALL  = 4'd7;
    localparam logic [3:0] OFF_DBPER = 4'd8;
endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-bit debounce filter: filt_o follows sync_i once it has differed for period_i+1 cycles.
// A mismatch that disappears early restarts the count, so shorter pulses never reach filt_o.
module gpio_debounce_bit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             filt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == period_i) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

// File: rtl/avalon_gpio_multi.sv
// Avalon-MM bidirectional GPIO with set/clear, per-bit edge capture and IRQ; read latency 1, no waitrequest.
// Optional per-bit debounce filter compiled in with GPIO_DEBOUNCE_EN.
module avalon_gpio_multi
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [GPIO_MAX_W-1:0] writedata,
    output logic [GPIO_MAX_W-1:0] readdata,
    output logic                  irq,
    inout  wire  [WIDTH-1:0]      bidir_port
);
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] data_dir_q, data_dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] s, s_d_q, ev;
    logic [WIDTH-1:0] wd;
    logic [GPIO_MAX_W-1:0] readdata_q, readdata_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic wr;
    wire  unused_wd = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bidir_port[gi] = data_dir_q[gi] ? data_out_q[gi] : 1'bz;
        assign ev[gi] = (s[gi] & ~s_d_q[gi] & rise_en_q[gi]) |
                        (~s[gi] & s_d_q[gi] & fall_en_q[gi]);
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] db_period_q, db_period_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        gpio_debounce_bit #(.CNT_W(DB_CNT_W)) u_db (
            .clk      (clk),
            .reset    (reset),
            .sync_i   (sync_q[SYNC_STAGES-1][gi]),
            .period_i (db_period_q),
            .filt_o   (s[gi])
        );
    end

    always_comb begin
        db_period_d = db_period_q;
        if (wr && address == OFF_DBPER) db_period_d = writedata[DB_CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) db_period_q <= '0;
        else       db_period_q <= db_period_d;
    end
`else
    wire [DB_CNT_W-1:0] unused_db = '0;
    assign s = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        data_out_d = data_out_q;
        data_dir_d = data_dir_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        edge_clr   = '0;
        if (wr) begin
            case (address)
                OFF_DATA: data_out_d = wd;
                OFF_DIR:  data_dir_d = wd;
                OFF_MASK: irq_mask_d = wd;
                OFF_EDGE: edge_clr   = wd;
                OFF_SET:  data_out_d = data_out_q | wd;
                OFF_CLR:  data_out_d = data_out_q & ~wd;
                OFF_RISE: rise_en_d  = wd;
                OFF_FALL: fall_en_d  = wd;
                default:  ;
            endcase
        end
        // a fresh event wins over a clear in the same cycle so no edge is lost
        edge_d = (edge_q & ~edge_clr) | ev;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            OFF_DATA:         readdata_d[WIDTH-1:0] = s;
            OFF_DIR:          readdata_d[WIDTH-1:0] = data_dir_q;
            OFF_MASK:         readdata_d[WIDTH-1:0] = irq_mask_q;
            OFF_EDGE:         readdata_d[WIDTH-1:0] = edge_q;
            OFF_SET, OFF_CLR: readdata_d[WIDTH-1:0] = data_out_q;
            OFF_RISE:         readdata_d[WIDTH-1:0] = rise_en_q;
            OFF_FALL:         readdata_d[WIDTH-1:0] = fall_en_q;
`ifdef GPIO_DEBOUNCE_EN
            OFF_DBPER:        readdata_d[DB_CNT_W-1:0] = db_period_q;
`endif
            default:          ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            data_dir_q <= '0;
            irq_mask_q <= '0;
            edge_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            s_d_q      <= '0;
            sync_q     <= '0;
            readdata_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            data_dir_q <= data_dir_d;
            irq_mask_q <= irq_mask_d;
            edge_q     <= edge_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            s_d_q      <= s;
            sync_q[0]  <= bidir_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & irq_mask_q);
endmodule

// File: tb/tb_avalon_gpio_multi.sv
// Directed bench for avalon_gpio_multi: register table plus hand-timed pin/edge/reset sequences.
module tb_avalon_gpio_multi;
    localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_ON = 1;
`else
    localparam int DB_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    wire  [15:0] pins;
    logic [15:0] tb_drv, tb_oe;
    logic [31:0] rd;
    int          n_tests = 0;
    int          n_fail  = 0;

    for (genvar g = 0; g < 16; g++) begin : g_pin
        assign pins[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
    end

    avalon_gpio_multi #(.WIDTH(16), .SYNC_STAGES(SS), .DB_CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .bidir_port (pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic [3:0]  waddr;
        logic [31:0] wdat;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic cs, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = cs; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        tb_drv = '0; tb_oe = '0;

        vecs[0]  = '{1'b1, 4'd0,  32'h0000_00F0, 4'd4,  32'h0000_00F0};
        vecs[1]  = '{1'b1, 4'd4,  32'h0000_000F, 4'd4,  32'h0000_00FF};
        vecs[2]  = '{1'b1, 4'd5,  32'h0000_0030, 4'd5,  32'h0000_00CF};
        vecs[3]  = '{1'b0, 4'd0,  32'h0000_FFFF, 4'd4,  32'h0000_00CF};
        vecs[4]  = '{1'b1, 4'd0,  32'hFFFF_00CF, 4'd4,  32'h0000_00CF};
        vecs[5]  = '{1'b1, 4'd2,  32'h0000_0003, 4'd2,  32'h0000_0003};
        vecs[6]  = '{1'b1, 4'd6,  32'h0000_0001, 4'd6,  32'h0000_0001};
        vecs[7]  = '{1'b1, 4'd7,  32'h0000_0002, 4'd7,  32'h0000_0002};
        vecs[8]  = '{1'b1, 4'd9,  32'h0000_FFFF, 4'd9,  32'h0000_0000};
        vecs[9]  = '{1'b1, 4'd15, 32'h0000_ABCD, 4'd15, 32'h0000_0000};
        vecs[10] = '{1'b1, 4'd8,  32'h0000_0055, 4'd8,  (DB_ON != 0) ? 32'h55 : 32'h0};
        vecs[11] = '{1'b1, 4'd8,  32'h0000_0000, 4'd8,  32'h0000_0000};
        vecs[12] = '{1'b1, 4'd1,  32'h0000_0000, 4'd1,  32'h0000_0000};

        repeat (2) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus_write(vecs[i].cs, vecs[i].waddr, vecs[i].wdat);
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // pins follow data_out once driven, visible at offset 0 after the synchroniser
        bus_write(1'b1, 4'd1, 32'hFFFF);
        address = 4'd0;
        repeat (1 + DB_ON) @(negedge clk);
        @(negedge clk);
        check("pin_rd_early", readdata, 32'h0);
        @(negedge clk);
        check("pin_rd", readdata, 32'h00CF);
        check("irq_pin_rise", {31'b0, irq}, 32'h1);
        bus_read(4'd3, rd);
        check("edge_pin_rise", rd, 32'h0001);
        tb_drv = 16'h00CF; tb_oe = 16'hFFFF;
        bus_write(1'b1, 4'd1, 32'h0);
        bus_write(1'b1, 4'd3, 32'hFFFF);
        bus_read(4'd3, rd);
        check("edge_clr_all", rd, 32'h0);
        check("irq_clr_all", {31'b0, irq}, 32'h0);

        // edge modes: rise on bit0, fall on bit1
        tb_drv = 16'h0000;
        repeat (4 + DB_ON) @(negedge clk);
        bus_write(1'b1, 4'd3, 32'hFFFF);
        tb_drv = 16'h0003;
        repeat (4 + DB_ON) @(negedge clk);
        bus_read(4'd3, rd);
        check("edge_rise_only", rd, 32'h0001);
        check("irq_rise", {31'b0, irq}, 32'h1);
        tb_drv = 16'h0001;
        repeat (4 + DB_ON) @(negedge clk);
        bus_read(4'd3, rd);
        check("edge_fall", rd, 32'h0003);
        bus_write(1'b1, 4'd2, 32'h0);
        check("irq_mask_off", {31'b0, irq}, 32'h0);
        bus_write(1'b1, 4'd2, 32'h3);
        check("irq_mask_on", {31'b0, irq}, 32'h1);
        bus_write(1'b1, 4'd6, 32'h0);
        bus_read(4'd3, rd);
        check("edge_keep_disable", rd, 32'h0003);
        bus_write(1'b1, 4'd3, 32'h0003);
        bus_read(4'd3, rd);
        check("edge_w1c", rd, 32'h0);
        check("irq_w1c", {31'b0, irq}, 32'h0);

        // pin-to-capture latency on bit2
        bus_write(1'b1, 4'd6, 32'h0004);
        bus_write(1'b1, 4'd2, 32'h0004);
        @(negedge clk);
        tb_drv = 16'h0005;
        repeat (SS + DB_ON) @(negedge clk);
        check("lat_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("lat_capture", {31'b0, irq}, 32'h1);
        bus_read(4'd3, rd);
        check("lat_readback", rd, 32'h0004);

        // clear lands on the same edge as a new rising event on bit0
        bus_write(1'b1, 4'd6, 32'h0005);
        bus_write(1'b1, 4'd2, 32'h0001);
        tb_drv = 16'h0004;
        repeat (4 + DB_ON) @(negedge clk);
        bus_write(1'b1, 4'd3, 32'hFFFF);
        @(negedge clk);
        tb_drv = 16'h0005;
        repeat (1 + DB_ON) @(negedge clk);
        bus_write(1'b1, 4'd3, 32'h0001);
        bus_read(4'd3, rd);
        check("clr_vs_event", rd, 32'h0001);
        check("irq_clr_vs_event", {31'b0, irq}, 32'h1);
        bus_write(1'b1, 4'd3, 32'h0001);
        bus_read(4'd3, rd);
        check("clr_after", rd, 32'h0);
        check("irq_clr_after", {31'b0, irq}, 32'h0);

        // asynchronous reset mid-run
        bus_write(1'b1, 4'd2, 32'hFFFF);
        bus_write(1'b1, 4'd6, 32'hFFFF);
        bus_write(1'b1, 4'd7, 32'hFFFF);
        tb_oe = 16'h0;
        bus_write(1'b1, 4'd0, 32'hA5A5);
        bus_write(1'b1, 4'd1, 32'hFFFF);
        repeat (4 + DB_ON) @(negedge clk);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        bus_read(4'd4, rd);
        check("pre_reset_dout", rd, 32'hA5A5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tb_drv = 16'h5A5A; tb_oe = 16'hFFFF;
        repeat (4 + DB_ON) @(negedge clk);
        bus_read(4'd0, rd);
        check("rst_pins_released", rd, 32'h5A5A);
        bus_read(4'd1, rd);
        check("rst_dir", rd, 32'h0);
        bus_read(4'd4, rd);
        check("rst_dout", rd, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        bus_write(1'b1, 4'd8, 32'h4);
        bus_write(1'b1, 4'd6, 32'h1);
        bus_write(1'b1, 4'd2, 32'h1);
        tb_drv = 16'h0;
        repeat (12) @(negedge clk);
        tb_drv = 16'h1;
        repeat (3) @(negedge clk);
        tb_drv = 16'h0;
        repeat (12) @(negedge clk);
        check("db_short_pulse", {31'b0, irq}, 32'h0);
        tb_drv = 16'h1;
        // last sync stage changes 2 edges after the pin; filter passes it 5 edges later
        repeat (SS + 5) @(negedge clk);
        check("db_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("db_capture", {31'b0, irq}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
